// File: rtl/alu_exec_sequencer_if.sv
// Bundle between the ALU issue/writeback sequencer and its requester/ALU side.
// The slave modport is the sequencer. The master modport is the requester plus the external ALU.
interface alu_exec_sequencer_if #(
  parameter int unsigned AW = 2
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_s;
  logic          instr_m;
  logic          instr_cin;
  logic          instr_use_cf;
  logic [AW-1:0] instr_ra;
  logic [AW-1:0] instr_rb;
  logic [AW-1:0] instr_rd;
  logic          instr_we;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [3:0]    alu_s;
  logic          alu_m;
  logic          alu_pin;
  logic [3:0]    alu_r;
  logic [3:0]    alu_p;
  logic          done;
  logic [3:0]    result;
  logic          carry_flag;
  logic          zero_flag;
  logic [AW-1:0] dbg_addr;
  logic [3:0]    dbg_data;

  modport slave (
    input  instr_valid, instr_s, instr_m, instr_cin, instr_use_cf,
           instr_ra, instr_rb, instr_rd, instr_we, alu_r, alu_p, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_s, alu_m, alu_pin,
           done, result, carry_flag, zero_flag, dbg_data
  );

  modport master (
    output instr_valid, instr_s, instr_m, instr_cin, instr_use_cf,
           instr_ra, instr_rb, instr_rd, instr_we, alu_r, alu_p, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_s, alu_m, alu_pin,
           done, result, carry_flag, zero_flag, dbg_data
  );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Issue/writeback sequencer around a 4-bit ALU: IDLE accepts, EXEC captures the ALU,
// and WB writes the result back. Each instruction takes 3 cycles.
module alu_exec_sequencer #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_exec_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic [3:0]    regs_q [NREGS];
  logic [3:0]    alu_a_q, alu_b_q, alu_s_q;
  logic          alu_m_q, alu_pin_q;
  logic [AW-1:0] rd_q;
  logic          we_q;
  logic [3:0]    result_q;
  logic          cf_q, zf_q;
  logic          accept;
  logic          ready;
  logic          done;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands and the carry flag are sampled at the accept edge, so the previous WB is already visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_s_q   <= '0;
      alu_m_q   <= 1'b0;
      alu_pin_q <= 1'b0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      result_q  <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q   <= regs_q[bus.instr_ra];
        alu_b_q   <= regs_q[bus.instr_rb];
        alu_s_q   <= bus.instr_s;
        alu_m_q   <= bus.instr_m;
        alu_pin_q <= bus.instr_use_cf ? cf_q : bus.instr_cin;
        rd_q      <= bus.instr_rd;
        we_q      <= bus.instr_we;
      end
      if (state_q == EXEC) begin
        result_q <= bus.alu_r;
        cf_q     <= bus.alu_p[3];
        zf_q     <= (bus.alu_r == 4'b0000);
      end
      if (state_q == WB && we_q) begin
        regs_q[rd_q] <= result_q;
      end
    end
  end

  assign bus.instr_ready = ready;
  assign bus.done        = done;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_s       = alu_s_q;
  assign bus.alu_m       = alu_m_q;
  assign bus.alu_pin     = alu_pin_q;
  assign bus.result      = result_q;
  assign bus.carry_flag  = cf_q;
  assign bus.zero_flag   = zf_q;
  assign bus.dbg_data    = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer. The bench acts as the ALU and returns hand-picked r/p values.
module tb_alu_exec_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_exec_sequencer_if #(.AW(2)) bus ();

  alu_exec_sequencer #(.NREGS(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Back-to-back instruction table
  logic [1:0] b_ra  [3] = '{2'd1, 2'd0, 2'd3};
  logic [1:0] b_rb  [3] = '{2'd2, 2'd0, 2'd2};
  logic [1:0] b_rd  [3] = '{2'd0, 2'd3, 2'd2};
  logic       b_ucf [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] b_r   [3] = '{4'h5, 4'hC, 4'h7};
  logic [3:0] b_p   [3] = '{4'h0, 4'h8, 4'h0};
  logic [3:0] b_ea  [3] = '{4'hA, 4'h5, 4'hC};
  logic [3:0] b_eb  [3] = '{4'h3, 4'h5, 4'h3};
  logic       b_epin[3] = '{1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [1:0] addr, input logic [3:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  task automatic do_op(input string tag, input logic [3:0] s, input logic m, input logic cin,
                       input logic use_cf, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic we, input logic [3:0] r,
                       input logic [3:0] p, input logic [3:0] exp_a, input logic [3:0] exp_b,
                       input logic exp_pin, input logic [3:0] exp_dbg);
    chk({tag, ".ready_idle"}, {3'b0, bus.instr_ready}, 4'h1);
    bus.instr_valid  = 1'b1;
    bus.instr_s      = s;
    bus.instr_m      = m;
    bus.instr_cin    = cin;
    bus.instr_use_cf = use_cf;
    bus.instr_ra     = ra;
    bus.instr_rb     = rb;
    bus.instr_rd     = rd;
    bus.instr_we     = we;
    bus.alu_r        = r;
    bus.alu_p        = p;
    tick();
    bus.instr_valid  = 1'b0;
    chk({tag, ".ready_exec"}, {3'b0, bus.instr_ready}, 4'h0);
    chk({tag, ".done_exec"},  {3'b0, bus.done}, 4'h0);
    chk({tag, ".alu_a"},      bus.alu_a, exp_a);
    chk({tag, ".alu_b"},      bus.alu_b, exp_b);
    chk({tag, ".alu_s"},      bus.alu_s, s);
    chk({tag, ".alu_m"},      {3'b0, bus.alu_m}, {3'b0, m});
    chk({tag, ".alu_pin"},    {3'b0, bus.alu_pin}, {3'b0, exp_pin});
    tick();
    chk({tag, ".done_wb"},    {3'b0, bus.done}, 4'h1);
    chk({tag, ".result"},     bus.result, r);
    chk({tag, ".carry"},      {3'b0, bus.carry_flag}, {3'b0, p[3]});
    chk({tag, ".zero"},       {3'b0, bus.zero_flag}, {3'b0, (r == 4'h0)});
    tick();
    chk({tag, ".done_after"}, {3'b0, bus.done}, 4'h0);
    chk({tag, ".a_hold"},     bus.alu_a, exp_a);
    chk_dbg({tag, ".dbg_rd"}, rd, exp_dbg);
  endtask

  initial begin
    bus.instr_valid  = 1'b0;
    bus.instr_s      = '0;
    bus.instr_m      = 1'b0;
    bus.instr_cin    = 1'b0;
    bus.instr_use_cf = 1'b0;
    bus.instr_ra     = '0;
    bus.instr_rb     = '0;
    bus.instr_rd     = '0;
    bus.instr_we     = 1'b0;
    bus.alu_r        = '0;
    bus.alu_p        = '0;
    bus.dbg_addr     = '0;

    tick();
    tick();
    rst = 1'b0;
    chk("rst.ready",  {3'b0, bus.instr_ready}, 4'h1);
    chk("rst.done",   {3'b0, bus.done}, 4'h0);
    chk("rst.result", bus.result, 4'h0);
    chk("rst.carry",  {3'b0, bus.carry_flag}, 4'h0);
    chk("rst.zero",   {3'b0, bus.zero_flag}, 4'h0);

    // Preload reg1=5, reg2=3
    do_op("pre1", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 4'h5);
    do_op("pre2", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 4'h3);
    do_op("basic", 4'h9, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b1, 4'h8, 4'h0, 4'h5, 4'h3, 1'b0, 4'h8);

    // Compare with we=0 producing carry and zero; reg3 must keep 8
    do_op("cmp", 4'h6, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 4'h0, 4'hF, 4'h5, 4'h3, 1'b1, 4'h8);
    do_op("cf1", 4'h9, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 2'd1, 1'b1, 4'hA, 4'h0, 4'h8, 4'h5, 1'b1, 4'hA);
    do_op("cf0", 4'h9, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 2'd2, 1'b0, 4'h1, 4'h8, 4'h3, 4'h8, 1'b0, 4'h3);

    // Back-to-back: valid stays high for 9 cycles and is accepted only in IDLE cycles
    bus.instr_valid = 1'b1;
    bus.instr_s     = 4'h3;
    bus.instr_m     = 1'b0;
    bus.instr_cin   = 1'b0;
    bus.instr_we    = 1'b1;
    for (int c = 0; c < 9; c++) begin
      automatic int k = c / 3;
      chk($sformatf("b2b.ready%0d", c), {3'b0, bus.instr_ready}, {3'b0, (c % 3 == 0)});
      chk($sformatf("b2b.done%0d", c),  {3'b0, bus.done}, {3'b0, (c % 3 == 2)});
      if (c % 3 == 0) begin
        bus.instr_ra     = b_ra[k];
        bus.instr_rb     = b_rb[k];
        bus.instr_rd     = b_rd[k];
        bus.instr_use_cf = b_ucf[k];
        bus.alu_r        = b_r[k];
        bus.alu_p        = b_p[k];
      end else if (c % 3 == 1) begin
        chk($sformatf("b2b.a%0d", k),   bus.alu_a, b_ea[k]);
        chk($sformatf("b2b.b%0d", k),   bus.alu_b, b_eb[k]);
        chk($sformatf("b2b.pin%0d", k), {3'b0, bus.alu_pin}, {3'b0, b_epin[k]});
      end else begin
        chk($sformatf("b2b.res%0d", k), bus.result, b_r[k]);
        chk($sformatf("b2b.cf%0d", k),  {3'b0, bus.carry_flag}, {3'b0, b_p[k][3]});
      end
      tick();
    end
    bus.instr_valid = 1'b0;
    chk("b2b.ready_end", {3'b0, bus.instr_ready}, 4'h1);
    chk_dbg("b2b.reg0", 2'd0, 4'h5);
    chk_dbg("b2b.reg3", 2'd3, 4'hC);
    chk_dbg("b2b.reg2", 2'd2, 4'h7);
    chk_dbg("b2b.reg1", 2'd1, 4'hA);

    // Alias: ra=rb=rd=0
    do_op("pre0",  4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 4'h7, 4'h0, 4'h5, 4'h5, 1'b0, 4'h7);
    do_op("alias", 4'h9, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 4'hE, 4'h0, 4'h7, 4'h7, 1'b0, 4'hE);

    // Set flags, then reset for two cycles starting mid-EXEC
    bus.instr_valid  = 1'b1;
    bus.instr_s      = 4'h9;
    bus.instr_m      = 1'b1;
    bus.instr_cin    = 1'b1;
    bus.instr_use_cf = 1'b0;
    bus.instr_ra     = 2'd1;
    bus.instr_rb     = 2'd2;
    bus.instr_rd     = 2'd1;
    bus.instr_we     = 1'b1;
    bus.alu_r        = 4'hF;
    bus.alu_p        = 4'hF;
    tick();
    bus.instr_valid  = 1'b0;
    chk("rstx.exec_a", bus.alu_a, 4'hA);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rstx.ready",  {3'b0, bus.instr_ready}, 4'h1);
    chk("rstx.done",   {3'b0, bus.done}, 4'h0);
    chk("rstx.result", bus.result, 4'h0);
    chk("rstx.carry",  {3'b0, bus.carry_flag}, 4'h0);
    chk("rstx.zero",   {3'b0, bus.zero_flag}, 4'h0);
    chk("rstx.alu_a",  bus.alu_a, 4'h0);
    chk("rstx.alu_b",  bus.alu_b, 4'h0);
    chk("rstx.alu_s",  bus.alu_s, 4'h0);
    chk("rstx.alu_m",  {3'b0, bus.alu_m}, 4'h0);
    chk("rstx.pin",    {3'b0, bus.alu_pin}, 4'h0);
    for (int i = 0; i < 4; i++) begin
      automatic logic [1:0] a = i[1:0];
      chk_dbg($sformatf("rstx.reg%0d", i), a, 4'h0);
    end
    tick();
    chk("rstx.done_next",  {3'b0, bus.done}, 4'h0);
    chk("rstx.ready_next", {3'b0, bus.instr_ready}, 4'h1);
    chk_dbg("rstx.reg1_next", 2'd1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
